// File: rtl/core_defs_pkg.sv
// Shared RV32I pipeline definitions: write-data source codes, load funct3 codes
// and the MEM/WB pipeline register layout.
package core_defs_pkg;

  localparam int PKG_XLEN       = 32;
  localparam int PKG_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RD_SRC_ALU  = 2'd0,
    RD_SRC_LOAD = 2'd1,
    RD_SRC_PC4  = 2'd2,
    RD_SRC_CSR  = 2'd3
  } rd_src_t;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef struct packed {
    logic                      valid;
    logic [PKG_REG_ADDR_W-1:0] rd_addr;
    logic                      rd_wr_en;
    rd_src_t                   rd_src;
    logic [2:0]                funct3;
    logic [PKG_XLEN-1:0]       alu;
    logic [PKG_XLEN-1:0]       load;
    logic [PKG_XLEN-1:0]       pc4;
    logic [PKG_XLEN-1:0]       csr;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_reg_if.sv
// MEM -> WB transfer bundle: valid/ready handshake plus the instruction payload.
interface wb_stage_reg_if
  import core_defs_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  mem_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  rd_wr_en;
  rd_src_t               rd_src;
  logic [2:0]            load_funct3;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       load_result;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       csr_rdata;

  modport master (
    output mem_valid, rd_addr, rd_wr_en, rd_src, load_funct3,
           alu_result, load_result, pc_plus4, csr_rdata,
    input  wb_ready
  );

  modport slave (
    input  mem_valid, rd_addr, rd_wr_en, rd_src, load_funct3,
           alu_result, load_result, pc_plus4, csr_rdata,
    output wb_ready
  );
endinterface

// File: rtl/wb_stage_reg_load_extract.sv
// Combinational load alignment: picks byte/half/word from an aligned memory word,
// sign- or zero-extends it, and flags halfword/word accesses that are misaligned.
module load_extract
  import core_defs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [31:0]     word_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Unassigned funct3 codes fall into the word path, alignment check included.
  always_comb begin
    data_o       = XLEN'($signed(word_i));
    misaligned_o = 1'b0;
    case (funct3_i)
      LOAD_LB:  data_o = XLEN'($signed(byte_sel));
      LOAD_LBU: data_o = XLEN'(byte_sel);
      LOAD_LH: begin
        data_o       = XLEN'($signed(half_sel));
        misaligned_o = addr_i[0];
      end
      LOAD_LHU: begin
        data_o       = XLEN'(half_sel);
        misaligned_o = addr_i[0];
      end
      default: begin
        data_o       = XLEN'($signed(word_i));
        misaligned_o = |addr_i;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage_reg.sv
// Registered RV32I write-back stage: MEM/WB register, load extraction, write-data
// select, regfile write port, forwarding tap and retired-instruction counter.
module wb_stage_reg
  import core_defs_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 32,
  parameter bit ZERO_REG_WRITE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  wb_stage_reg_if.slave         mem_if,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] WB_rd_addr_o,
  output logic                  WB_rd_wr_en_o,
  output logic [XLEN-1:0]       WB_wr_data_o,
  output logic                  WB_fwd_valid_o,
  output logic                  WB_misaligned_o,
  output logic [CNT_W-1:0]      WB_retired_o
);

  mem_wb_t          wb_q, wb_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             capture;
  logic [XLEN-1:0]  load_data;
  logic             load_misaligned;
  logic             misaligned;

  assign mem_if.wb_ready = !stall_i;
  assign capture         = mem_if.mem_valid && !stall_i && !flush_i;

  // The counter ticks when a live instruction is accepted, so a stalled
  // instruction is counted exactly once however long it sits in WB.
  always_comb begin
    wb_d      = wb_q;
    retired_d = retired_q;
    if (!stall_i) begin
      if (capture) begin
        wb_d.valid    = 1'b1;
        wb_d.rd_addr  = mem_if.rd_addr;
        wb_d.rd_wr_en = mem_if.rd_wr_en;
        wb_d.rd_src   = mem_if.rd_src;
        wb_d.funct3   = mem_if.load_funct3;
        wb_d.alu      = mem_if.alu_result;
        wb_d.load     = mem_if.load_result;
        wb_d.pc4      = mem_if.pc_plus4;
        wb_d.csr      = mem_if.csr_rdata;
        retired_d     = retired_q + 1'b1;
      end else begin
        wb_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .funct3_i     (wb_q.funct3),
    .addr_i       (wb_q.alu[1:0]),
    .word_i       (wb_q.load),
    .data_o       (load_data),
    .misaligned_o (load_misaligned)
  );

  assign misaligned = wb_q.valid && (wb_q.rd_src == RD_SRC_LOAD) && load_misaligned;

  always_comb begin
    WB_wr_data_o = wb_q.alu;
    case (wb_q.rd_src)
      RD_SRC_ALU:  WB_wr_data_o = wb_q.alu;
      RD_SRC_LOAD: WB_wr_data_o = load_data;
      RD_SRC_PC4:  WB_wr_data_o = wb_q.pc4;
      default:     WB_wr_data_o = wb_q.csr;
    endcase
  end

  assign WB_rd_addr_o    = wb_q.rd_addr;
  assign WB_rd_wr_en_o   = wb_q.valid && wb_q.rd_wr_en && !misaligned &&
                           (ZERO_REG_WRITE || (wb_q.rd_addr != '0));
  assign WB_fwd_valid_o  = WB_rd_wr_en_o;
  assign WB_misaligned_o = misaligned;
  assign WB_retired_o    = retired_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg; a second instance (4-bit counter, x0 writes
// allowed) mirrors the same stimulus for wrap and x0 behaviour.
module tb_wb_stage_reg;
  import core_defs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, stall, flush;
  int   errors = 0;
  int   checks = 0;
  int   exp_ret = 0;

  wb_stage_reg_if mif ();
  wb_stage_reg_if mif4 ();

  assign mif4.mem_valid   = mif.mem_valid;
  assign mif4.rd_addr     = mif.rd_addr;
  assign mif4.rd_wr_en    = mif.rd_wr_en;
  assign mif4.rd_src      = mif.rd_src;
  assign mif4.load_funct3 = mif.load_funct3;
  assign mif4.alu_result  = mif.alu_result;
  assign mif4.load_result = mif.load_result;
  assign mif4.pc_plus4    = mif.pc_plus4;
  assign mif4.csr_rdata   = mif.csr_rdata;

  logic [4:0]  wb_addr, wb_addr4;
  logic        wb_we, wb_we4, wb_fwd, wb_fwd4, wb_mis, wb_mis4;
  logic [31:0] wb_data, wb_data4, wb_ret;
  logic [3:0]  wb_ret4;

  wb_stage_reg dut (
    .clk_i (clk), .rst_ni (rst_n), .mem_if (mif.slave),
    .stall_i (stall), .flush_i (flush),
    .WB_rd_addr_o (wb_addr), .WB_rd_wr_en_o (wb_we), .WB_wr_data_o (wb_data),
    .WB_fwd_valid_o (wb_fwd), .WB_misaligned_o (wb_mis), .WB_retired_o (wb_ret)
  );

  wb_stage_reg #(.CNT_W(4), .ZERO_REG_WRITE(1'b1)) dut4 (
    .clk_i (clk), .rst_ni (rst_n), .mem_if (mif4.slave),
    .stall_i (stall), .flush_i (flush),
    .WB_rd_addr_o (wb_addr4), .WB_rd_wr_en_o (wb_we4), .WB_wr_data_o (wb_data4),
    .WB_fwd_valid_o (wb_fwd4), .WB_misaligned_o (wb_mis4), .WB_retired_o (wb_ret4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input rd_src_t src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4, input logic [31:0] csr);
    mif.mem_valid   = v;
    mif.rd_addr     = rd;
    mif.rd_wr_en    = we;
    mif.rd_src      = src;
    mif.load_funct3 = f3;
    mif.alu_result  = alu;
    mif.load_result = ld;
    mif.pc_plus4    = pc4;
    mif.csr_rdata   = csr;
  endtask

  task automatic idle();
    mif.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 1'b1, RD_SRC_CSR, LOAD_LW, 32'h11, 32'h22, 32'h33, 32'h44);
    step(); step();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wb_we); end
    checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    checks++; if ({wb_fwd, wb_mis} !== 2'b00) begin errors++; $display("FAIL reset_fwd_mis got=%b exp=00", {wb_fwd, wb_mis}); end
    checks++; if (wb_ret !== 32'd0 || wb_ret4 !== 4'd0) begin errors++; $display("FAIL reset_retired got=%0d/%0d exp=0/0", wb_ret, wb_ret4); end
    idle();
    rst_n = 1'b1;
    step();
    exp_ret = 0;
    checks++; if (wb_we !== 1'b0 || wb_ret !== 32'd0) begin errors++; $display("FAIL idle_after_reset we=%b ret=%0d exp=0/0", wb_we, wb_ret); end
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd5, 1'b1, RD_SRC_ALU, LOAD_LW, 32'h0000_1234, 32'hFFFF_FFFF, 32'h4, 32'h8);
    checks++; if (mif.wb_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got=%b exp=1", mif.wb_ready); end
    step(); idle(); exp_ret++;
    checks++; if (wb_we !== 1'b1 || wb_fwd !== 1'b1) begin errors++; $display("FAIL basic_we got=%b/%b exp=1/1", wb_we, wb_fwd); end
    checks++; if (wb_addr !== 5'd5) begin errors++; $display("FAIL basic_addr got=%0d exp=5", wb_addr); end
    checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL basic_data got=%h exp=00001234", wb_data); end
    checks++; if (wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL basic_retired got=%0d exp=%0d", wb_ret, exp_ret); end
    step();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL basic_drain_we got=%b exp=0", wb_we); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6];
    logic [1:0]  ad  [6];
    logic [31:0] exp [6];
    f3 = '{LOAD_LB, LOAD_LB, LOAD_LHU, LOAD_LH, LOAD_LW, LOAD_LBU};
    ad = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11};
    exp = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h80FF_7F01, 32'h0000_0080};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd7, 1'b1, RD_SRC_LOAD, f3[i], {30'h400, ad[i]}, 32'h80FF_7F01, 32'h0, 32'h0);
      step(); idle(); exp_ret++;
      checks++;
      if (wb_data !== exp[i] || wb_we !== 1'b1 || wb_mis !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d f3=%b addr=%b got data=%h we=%b mis=%b exp data=%h we=1 mis=0",
                 i, f3[i], ad[i], wb_data, wb_we, wb_mis, exp[i]);
      end
    end
    step();
  endtask

  task automatic test_misaligned();
    logic [2:0] f3 [2];
    logic [1:0] ad [2];
    f3 = '{LOAD_LW, LOAD_LH};
    ad = '{2'b10, 2'b01};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd8, 1'b1, RD_SRC_LOAD, f3[i], {30'h10, ad[i]}, 32'h1234_5678, 32'h0, 32'h0);
      step(); idle(); exp_ret++;
      checks++; if (wb_we !== 1'b0 || wb_fwd !== 1'b0 || wb_mis !== 1'b1) begin errors++; $display("FAIL misalign_%0d got we=%b fwd=%b mis=%b exp 0/0/1", i, wb_we, wb_fwd, wb_mis); end
      checks++; if (wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL misalign_ret_%0d got=%0d exp=%0d", i, wb_ret, exp_ret); end
      step();
      checks++; if (wb_mis !== 1'b0) begin errors++; $display("FAIL misalign_pulse_%0d got=%b exp=0", i, wb_mis); end
    end
    drive(1'b1, 5'd8, 1'b1, RD_SRC_LOAD, LOAD_LW, 32'h0000_0003, 32'h0, 32'h0, 32'h0);
    step(); exp_ret++;
    stall = 1'b1;
    step(); step();
    checks++; if (wb_mis !== 1'b1 || wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL misalign_stall got mis=%b ret=%0d exp 1/%0d", wb_mis, wb_ret, exp_ret); end
    stall = 1'b0; idle();
    step();
    checks++; if (wb_mis !== 1'b0 || wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL misalign_release got mis=%b ret=%0d exp 0/%0d", wb_mis, wb_ret, exp_ret); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 5'd3, 1'b1, RD_SRC_ALU, LOAD_LW, 32'h0000_ABCD, 32'h0, 32'h0, 32'h0);
    step(); exp_ret++;
    stall = 1'b1;
    drive(1'b1, 5'd4, 1'b1, RD_SRC_ALU, LOAD_LW, 32'h0000_5555, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if (mif.wb_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", mif.wb_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (wb_data !== 32'h0000_ABCD || wb_addr !== 5'd3 || wb_we !== 1'b1 || wb_ret !== 32'(exp_ret)) begin
        errors++;
        $display("FAIL stall_hold_%0d got data=%h addr=%0d we=%b ret=%0d exp ABCD/3/1/%0d", c, wb_data, wb_addr, wb_we, wb_ret, exp_ret);
      end
    end
    flush = 1'b1;
    step();
    checks++; if (wb_we !== 1'b1 || wb_data !== 32'h0000_ABCD) begin errors++; $display("FAIL flush_in_stall got we=%b data=%h exp 1/ABCD", wb_we, wb_data); end
    flush = 1'b0; stall = 1'b0;
    step(); idle(); exp_ret++;
    checks++; if (wb_data !== 32'h0000_5555 || wb_addr !== 5'd4 || wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL stall_release got data=%h addr=%0d ret=%0d exp 5555/4/%0d", wb_data, wb_addr, wb_ret, exp_ret); end
    drive(1'b1, 5'd6, 1'b1, RD_SRC_ALU, LOAD_LW, 32'h0000_0666, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step(); idle(); flush = 1'b0;
    checks++; if (wb_we !== 1'b0 || wb_fwd !== 1'b0 || wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL flush_capture got we=%b fwd=%b ret=%0d exp 0/0/%0d", wb_we, wb_fwd, wb_ret, exp_ret); end
  endtask

  task automatic test_x0_sources();
    drive(1'b1, 5'd0, 1'b1, RD_SRC_ALU, LOAD_LW, 32'h0000_0077, 32'h0, 32'h0, 32'h0);
    step(); exp_ret++;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_suppressed got=%b exp=0", wb_we); end
    checks++; if (wb_we4 !== 1'b1 || wb_data4 !== 32'h77) begin errors++; $display("FAIL x0_allowed got we=%b data=%h exp 1/77", wb_we4, wb_data4); end
    drive(1'b1, 5'd1, 1'b1, RD_SRC_PC4, LOAD_LW, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0000_0100, 32'hDEAD_BEEF);
    step(); exp_ret++;
    checks++; if (wb_data !== 32'h0000_0100 || wb_we !== 1'b1) begin errors++; $display("FAIL src_pc4 got data=%h we=%b exp 00000100/1", wb_data, wb_we); end
    drive(1'b1, 5'd2, 1'b1, RD_SRC_CSR, LOAD_LW, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0000_0100, 32'hDEAD_BEEF);
    step(); idle(); exp_ret++;
    checks++; if (wb_data !== 32'hDEAD_BEEF || wb_addr !== 5'd2) begin errors++; $display("FAIL src_csr got data=%h addr=%0d exp DEADBEEF/2", wb_data, wb_addr); end
    checks++; if (wb_ret !== 32'(exp_ret)) begin errors++; $display("FAIL src_retired got=%0d exp=%0d", wb_ret, exp_ret); end
    step();
  endtask

  task automatic test_back_to_back_wrap();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 5'd10, 1'b1, RD_SRC_ALU, LOAD_LW, 32'(i * 3), 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (wb_data !== 32'(i * 3) || wb_we !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got data=%0d we=%b exp %0d/1", i, wb_data, wb_we, i * 3);
      end
    end
    idle();
    checks++; if (wb_ret !== 32'd17) begin errors++; $display("FAIL wrap_wide got=%0d exp=17", wb_ret); end
    checks++; if (wb_ret4 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got=%0d exp=1", wb_ret4); end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_loads();
    test_misaligned();
    test_stall_flush();
    test_x0_sources();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
Parametrised, registered write-back stage for the 5-stage RV32I pipeline. It sits between the MEM stage and the register file.
- Captures MEM results into a MEM/WB pipeline register using a valid/ready handshake.
- Performs load byte/half extraction and sign/zero extension.
- Selects among four write-data sources.
- Drives the register-file write port, a forwarding tap and a retired-instruction counter.
- Adds stall, flush and misalignment handling, which the earlier combinational write-back does not have.

Parameters:
XLEN, 32, datapath width. Must be 32 in this core; kept generic for a future RV64 build.
REG_ADDR_W, 5, register address width.
CNT_W, 32, retired-instruction counter width.
ZERO_REG_WRITE, 0, when 0, writes to x0 are suppressed (wr_en forced low).

Ports:
clk_i  in  1  core clock
rst_ni  in  1  synchronous, active-low reset
MEM_valid_i  in  1  MEM stage presents a valid instruction
WB_ready_o  out  1  WB can accept this cycle
stall_i  in  1  hold WB register (external hazard/regfile busy)
flush_i  in  1  kill the instruction entering WB this cycle
MEM_rd_addr_i  in  REG_ADDR_W  destination register
MEM_rd_wr_en_i  in  1  instruction writes rd
MEM_rd_src_i  in  2  write-data source select
MEM_load_funct3_i  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101)
MEM_ALU_result_i  in  XLEN  ALU result / load effective address
MEM_Load_result_i  in  XLEN  raw aligned 32-bit word read from memory
MEM_pc_plus4_i  in  XLEN  link value for JAL/JALR
MEM_csr_rdata_i  in  XLEN  CSR read data
WB_rd_addr_o  out  REG_ADDR_W  regfile write address
WB_rd_wr_en_o  out  1  regfile write enable
WB_wr_data_o  out  XLEN  regfile write data
WB_fwd_valid_o  out  1  forwarding tap valid (same cycle as WB write)
WB_misaligned_o  out  1  one-cycle pulse: misaligned load retired in WB
WB_retired_o  out  CNT_W  count of retired (valid, non-flushed) instructions

Behaviour:
- Reset (rst_ni=0 at posedge):
  - valid register = 0; all captured fields = 0; retired counter = 0.
  - Outputs: WB_rd_wr_en_o=0, WB_rd_addr_o=0, WB_wr_data_o=0, WB_fwd_valid_o=0, WB_misaligned_o=0.
  - Reset overrides stall and flush.
- Handshake:
  - WB_ready_o = !stall_i (combinational).
  - Capture happens when MEM_valid_i && WB_ready_o.
  - On stall_i=1 the register holds its contents and outputs are unchanged.
  - Write-enable stays asserted during a stall. A repeated write of the same value is harmless.
- Flush:
  - When flush_i=1 and not stalled, the register loads valid=0.
  - Flush has priority over a capture in the same cycle.
  - Flush during stall: the stall wins and the flush is ignored. The upstream hazard unit must re-assert it.
- Latency: one cycle from capture to WB outputs.
- Source decode (package constants):
  - RD_SRC_ALU=0 → ALU result.
  - RD_SRC_LOAD=1 → extracted load.
  - RD_SRC_PC4=2 → pc_plus4.
  - RD_SRC_CSR=3 → CSR data.
- Load extraction uses the registered addr[1:0] = ALU_result[1:0]:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the whole word.
  - Signed types sign-extend to XLEN; unsigned types zero-extend.
  - Undefined funct3 values (011, 110, 111) behave as LW.
- Misalignment (evaluated only when src=LOAD):
  - LH/LHU with addr[0]=1 is misaligned; LW with addr[1:0]≠0 is misaligned.
  - A misaligned load forces WB_rd_wr_en_o=0 and pulses WB_misaligned_o for the cycle the instruction is valid in WB. On a stall the pulse stays high, but it counts once.
- Write enable: WB_rd_wr_en_o = valid & rd_wr_en & !misaligned & (ZERO_REG_WRITE | rd_addr≠0).
- WB_fwd_valid_o equals WB_rd_wr_en_o.
- Retired counter:
  - Increments by 1 on each cycle where valid=1 and the register advances (not stalled), including misaligned loads.
  - Wraps modulo 2^CNT_W with no saturation.
- Outputs are driven from the register plus combinational extraction/mux. There is no path from MEM inputs to outputs in the same cycle.

Decomposition:
- Package core_defs_pkg holds:
  - RD_SRC_* constants and the rd_src_t typedef (2-bit).
  - LOAD_* funct3 constants.
  - The mem_wb_t struct (valid, rd_addr, rd_wr_en, rd_src, funct3, alu, load, pc4, csr).
- Sub-module load_extract: combinational; funct3, addr[1:0] and word in → extended data and misaligned flag out.

Test Plan:
- Reset: rst_ni=0 for 2 cycles with MEM_valid_i=1 → all outputs 0, WB_retired_o=0.
- Basic path: capture ALU result 0x0000_1234, rd=5, src=ALU → next cycle wr_en=1, addr=5, data=0x1234, retired=1.
- Loads with word 0x80FF_7F01:
  - LB at addr..01 → 0x0000_007F.
  - LB at addr..11 → 0xFFFF_FF80.
  - LHU at addr..10 → 0x0000_80FF.
  - LH at addr..10 → 0xFFFF_80FF.
- Misaligned load: LW at addr..10 → wr_en=0 and misaligned_o=1 for one cycle, retired still increments. LH at addr..01 behaves the same.
- Stall, flush and x0:
  - stall_i held 3 cycles → outputs stable, WB_ready_o=0, counter frozen.
  - flush_i together with a capture → wr_en=0 next cycle, counter unchanged.
  - rd=0 with ZERO_REG_WRITE=0 → wr_en=0.
- PC4/CSR sources and counter wrap:
  - src=PC4 with pc4=0x100 → data 0x100.
  - src=CSR → CSR data.
  - CNT_W=4 with 17 retirements → WB_retired_o=1.
